// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes, jump conditions,
// flag bit positions and the retire-size helper.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMemRd,
        StLcdWait,
        StHalt
    } state_e;

    localparam logic [3:0] OpMovReg = 4'h0;
    localparam logic [3:0] OpMovImm = 4'h1;
    localparam logic [3:0] OpLd     = 4'h2;
    localparam logic [3:0] OpSt     = 4'h3;
    localparam logic [3:0] OpPrnt   = 4'h4;
    localparam logic [3:0] OpAlu    = 4'h5;
    localparam logic [3:0] OpJmp    = 4'h6;
    localparam logic [3:0] OpHlt    = 4'h7;

    localparam logic [2:0] CcAlways = 3'b000;
    localparam logic [2:0] CcZ      = 3'b001;
    localparam logic [2:0] CcNz     = 3'b010;
    localparam logic [2:0] CcC      = 3'b011;
    localparam logic [2:0] CcNc     = 3'b100;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagC = 1;

    // Instruction length in bytes, reported to the PC alongside retire.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        if (op[3]) begin
            return 2'd1;
        end
        case (op)
            OpMovImm, OpLd, OpSt, OpAlu: return 2'd2;
            OpJmp:                       return 2'd3;
            default:                     return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch-side bundle: instruction handshake plus the retire and jump feedback to the PC unit.
interface instr_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9
);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_byte;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              retire;
    logic [1:0]        instr_size;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;

    modport master (
        output instr_valid, instr_byte, operand1, operand2,
        input  instr_ready, retire, instr_size, jmp_en, jmp_addr
    );

    modport slave (
        input  instr_valid, instr_byte, operand1, operand2,
        output instr_ready, retire, instr_size, jmp_en, jmp_addr
    );
endinterface

// File: rtl/seq_cond_unit.sv
// Jump condition evaluation: condition code plus live flags decide whether a JMP is taken.
module seq_cond_unit
    import seq_pkg::*;
(
    input  logic [2:0] i_cc,
    input  logic [7:0] i_flags,
    output logic       o_take
);
    logic w_unused_flags;
    assign w_unused_flags = ^i_flags;

    always_comb begin
        o_take = 1'b0;
        case (i_cc)
            CcAlways: o_take = 1'b1;
            CcZ:      o_take = i_flags[FlagZ];
            CcNz:     o_take = ~i_flags[FlagZ];
            CcC:      o_take = i_flags[FlagC];
            CcNc:     o_take = ~i_flags[FlagC];
            default:  o_take = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction per handshake and steps it through
// the register, ALU, SRAM, LCD and jump paths before pulsing retire with the instruction size.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned SRAM_LAT    = 1,
    parameter int unsigned LCD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              sys_rst,
    instr_sequencer_if.slave  fetch,
    input  logic [DATA_W-1:0] i_reg_a,
    input  logic [DATA_W-1:0] i_reg_b,
    input  logic [DATA_W-1:0] i_reg_c,
    input  logic [DATA_W-1:0] i_reg_d,
    input  logic [7:0]        i_reg_flags,
    output logic              o_reg_we,
    output logic [1:0]        o_reg_addr,
    output logic [DATA_W-1:0] o_reg_data,
    output logic [2:0]        o_alu_inst,
    output logic [DATA_W-1:0] o_op_1,
    output logic [DATA_W-1:0] o_op_2,
    input  logic [DATA_W-1:0] i_res,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_rd_en,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [7:0]        o_lcd_data,
    output logic              o_strt,
    input  logic              i_lcd_done,
    output logic              o_hlt,
    output logic              o_illegal,
    output logic              o_lcd_err
);
    localparam int unsigned LAT_CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam int unsigned LCD_CNT_W = (LCD_TIMEOUT > 1) ? $clog2(LCD_TIMEOUT) : 1;
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(SRAM_LAT - 1);
    localparam logic [LCD_CNT_W-1:0] LCD_LAST = LCD_CNT_W'(LCD_TIMEOUT - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [7:0]            r_instr;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;
    logic [LCD_CNT_W-1:0]  r_lcd_cnt;
    logic                  r_lcd_fin;
    logic                  r_lcd_err;
    logic [7:0]            r_lcd_data;

    logic [3:0]            w_opcode;
    logic [1:0]            w_dst;
    logic [1:0]            w_src;
    logic [DATA_W-1:0]     w_regs [4];
    logic [DATA_W-1:0]     w_dst_val;
    logic [DATA_W-1:0]     w_src_val;
    logic [2*DATA_W-1:0]   w_op_wide;
    logic [2*DATA_W-1:0]   w_op1_ext;
    logic [ADDR_W-1:0]     w_sram_addr;
    logic                  w_take;
    logic                  w_accept;
    logic                  w_lcd_timeout;
    logic                  w_ready;
    logic                  w_retire;
    logic                  w_jmp_en;
    logic                  w_unused_bits;

    assign w_opcode  = r_instr[7:4];
    assign w_dst     = r_instr[3:2];
    assign w_src     = r_instr[1:0];
    assign w_regs[0] = i_reg_a;
    assign w_regs[1] = i_reg_b;
    assign w_regs[2] = i_reg_c;
    assign w_regs[3] = i_reg_d;
    assign w_dst_val = w_regs[w_dst];
    assign w_src_val = w_regs[w_src];

    // Both address outputs come from a double-width view so ADDR_W may exceed DATA_W.
    assign w_op_wide     = {r_op2, r_op1};
    assign w_op1_ext     = {{DATA_W{1'b0}}, r_op1};
    assign w_sram_addr   = w_op1_ext[ADDR_W-1:0];
    assign w_unused_bits = ^{w_op_wide, w_op1_ext};

    assign w_accept      = (r_state == StIdle) && fetch.instr_valid;
    assign w_lcd_timeout = (LCD_TIMEOUT != 0) && (r_lcd_cnt == LCD_LAST);

    seq_cond_unit u_cond (
        .i_cc    (r_instr[2:0]),
        .i_flags (i_reg_flags),
        .o_take  (w_take)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_instr    <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_lat_cnt  <= '0;
            r_lcd_cnt  <= '0;
            r_lcd_fin  <= 1'b0;
            r_lcd_err  <= 1'b0;
            r_lcd_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_instr <= fetch.instr_byte;
                r_op1   <= fetch.operand1;
                r_op2   <= fetch.operand2;
            end
            r_lat_cnt <= (r_state == StMemRd) ? r_lat_cnt + 1'b1 : '0;
            if (r_state == StExec) begin
                r_lcd_data <= w_src_val[7:0];
            end
            // Finish is registered so retire lands the cycle after lcd_done or timeout.
            if (r_state == StLcdWait) begin
                if (!r_lcd_fin) begin
                    r_lcd_cnt <= r_lcd_cnt + 1'b1;
                    if (i_lcd_done) begin
                        r_lcd_fin <= 1'b1;
                    end else if (w_lcd_timeout) begin
                        r_lcd_fin <= 1'b1;
                        r_lcd_err <= 1'b1;
                    end
                end
            end else begin
                r_lcd_cnt <= '0;
                r_lcd_fin <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_retire     = 1'b0;
        w_jmp_en     = 1'b0;
        o_reg_we     = 1'b0;
        o_reg_addr   = 2'd0;
        o_reg_data   = '0;
        o_alu_inst   = 3'd0;
        o_op_1       = '0;
        o_op_2       = '0;
        o_sram_addr  = '0;
        o_rd_en      = 1'b0;
        o_wr_en      = 1'b0;
        o_sram_wdata = '0;
        o_lcd_data   = 8'd0;
        o_strt       = 1'b0;
        o_hlt        = 1'b0;
        o_illegal    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_ready = 1'b1;
                if (fetch.instr_valid) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_state_next = StIdle;
                if (w_opcode[3]) begin
                    o_illegal = 1'b1;
                    w_retire  = 1'b1;
                end else begin
                    case (w_opcode)
                        OpMovReg: begin
                            o_reg_we   = 1'b1;
                            o_reg_addr = w_dst;
                            o_reg_data = w_src_val;
                            w_retire   = 1'b1;
                        end
                        OpMovImm: begin
                            o_reg_we   = 1'b1;
                            o_reg_addr = w_dst;
                            o_reg_data = r_op1;
                            w_retire   = 1'b1;
                        end
                        OpLd: begin
                            o_rd_en      = 1'b1;
                            o_sram_addr  = w_sram_addr;
                            w_state_next = StMemRd;
                        end
                        OpSt: begin
                            o_wr_en      = 1'b1;
                            o_sram_addr  = w_sram_addr;
                            o_sram_wdata = w_src_val;
                            w_retire     = 1'b1;
                        end
                        OpPrnt: begin
                            o_strt       = 1'b1;
                            o_lcd_data   = w_src_val[7:0];
                            w_state_next = StLcdWait;
                        end
                        OpAlu: begin
                            o_alu_inst = r_op1[2:0];
                            o_op_1     = w_dst_val;
                            o_op_2     = w_src_val;
                            o_reg_we   = 1'b1;
                            o_reg_addr = w_dst;
                            o_reg_data = i_res;
                            w_retire   = 1'b1;
                        end
                        OpJmp: begin
                            w_jmp_en = w_take;
                            w_retire = 1'b1;
                        end
                        OpHlt: begin
                            w_retire     = 1'b1;
                            w_state_next = StHalt;
                        end
                        default: begin
                            w_retire = 1'b1;
                        end
                    endcase
                end
            end
            StMemRd: begin
                o_sram_addr = w_sram_addr;
                if (r_lat_cnt == LAT_LAST) begin
                    o_reg_we     = 1'b1;
                    o_reg_addr   = w_dst;
                    o_reg_data   = i_sram_rdata;
                    w_retire     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StLcdWait: begin
                o_lcd_data = r_lcd_data;
                if (r_lcd_fin) begin
                    w_retire     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StHalt: begin
                o_hlt = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_lcd_err         = r_lcd_err;
    assign fetch.instr_ready = w_ready;
    assign fetch.retire      = w_retire;
    assign fetch.instr_size  = w_retire ? op_size(w_opcode) : 2'd0;
    assign fetch.jmp_en      = w_jmp_en;
    assign fetch.jmp_addr    = w_op_wide[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random instructions checked
// against a behavioural model of each instruction's effect and timing.
module tb_instr_sequencer;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 9;
    localparam int unsigned LAT = 3;
    localparam int unsigned TMO = 16;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       rd;
        logic       wr;
        logic [8:0] saddr;
        logic [7:0] wdata;
        logic       strt;
        logic [7:0] lcd;
        logic       jmp;
        logic       ret;
        logic [1:0] size;
        logic       ill;
        logic [2:0] alu;
        logic [7:0] o1;
        logic [7:0] o2;
    } exp_t;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [7:0]    regs [4];
    logic [7:0]    reg_flags;
    logic          reg_we;
    logic [1:0]    reg_addr;
    logic [DW-1:0] reg_data;
    logic [2:0]    alu_inst;
    logic [DW-1:0] op_1;
    logic [DW-1:0] op_2;
    logic [DW-1:0] res;
    logic [AW-1:0] sram_addr;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [7:0]    lcd_data;
    logic          strt;
    logic          lcd_done;
    logic          hlt;
    logic          illegal;
    logic          lcd_err;

    int n_chk = 0;
    int n_err = 0;
    logic exp_lcd_err = 1'b0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) fetch ();

    instr_sequencer #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .SRAM_LAT    (LAT),
        .LCD_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .fetch        (fetch.slave),
        .i_reg_a      (regs[0]),
        .i_reg_b      (regs[1]),
        .i_reg_c      (regs[2]),
        .i_reg_d      (regs[3]),
        .i_reg_flags  (reg_flags),
        .o_reg_we     (reg_we),
        .o_reg_addr   (reg_addr),
        .o_reg_data   (reg_data),
        .o_alu_inst   (alu_inst),
        .o_op_1       (op_1),
        .o_op_2       (op_2),
        .i_res        (res),
        .o_sram_addr  (sram_addr),
        .o_rd_en      (rd_en),
        .o_wr_en      (wr_en),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata),
        .o_lcd_data   (lcd_data),
        .o_strt       (strt),
        .i_lcd_done   (lcd_done),
        .o_hlt        (hlt),
        .o_illegal    (illegal),
        .o_lcd_err    (lcd_err)
    );

    function automatic logic [7:0] alu_ref(input logic [2:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return b;
        endcase
    endfunction

    // Environment ALU: the DUT expects a combinational result for whatever it presents.
    assign res = alu_ref(alu_inst, op_1, op_2);

    function automatic logic cond_ref(input logic [2:0] cc, input logic [7:0] f);
        case (cc)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return !f[0];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model_exec(input logic [7:0] ib, input logic [7:0] o1,
                                        input logic [7:0] o2);
        exp_t e;
        int op;
        logic [1:0] d;
        logic [7:0] dv;
        logic [7:0] sv;
        op = int'(ib[7:4]);
        d  = ib[3:2];
        dv = regs[ib[3:2]];
        sv = regs[ib[1:0]];
        e  = '{default: '0};
        if (op >= 8) begin
            e.ill = 1'b1; e.ret = 1'b1; e.size = 2'd1;
            return e;
        end
        case (op)
            0: begin e.we = 1'b1; e.addr = d; e.data = sv; e.ret = 1'b1; e.size = 2'd1; end
            1: begin e.we = 1'b1; e.addr = d; e.data = o1; e.ret = 1'b1; e.size = 2'd2; end
            2: begin e.rd = 1'b1; e.saddr = 9'(o1); end
            3: begin
                e.wr = 1'b1; e.saddr = 9'(o1); e.wdata = sv; e.ret = 1'b1; e.size = 2'd2;
            end
            4: begin e.strt = 1'b1; e.lcd = sv; end
            5: begin
                e.alu = o1[2:0]; e.o1 = dv; e.o2 = sv;
                e.we = 1'b1; e.addr = d; e.data = alu_ref(o1[2:0], dv, sv);
                e.ret = 1'b1; e.size = 2'd2;
            end
            6: begin e.jmp = cond_ref(ib[2:0], reg_flags); e.ret = 1'b1; e.size = 2'd3; end
            default: begin e.ret = 1'b1; e.size = 2'd1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, fetch.instr_ready, 1);
        chk({tag, "_strobes"}, {reg_we, rd_en, wr_en, strt, fetch.retire, fetch.jmp_en}, 0);
        chk({tag, "_status"}, {hlt, illegal, lcd_err}, 0);
        chk({tag, "_lcd_data"}, lcd_data, 0);
        chk({tag, "_jmp_addr"}, fetch.jmp_addr, 0);
    endtask

    // Issue one instruction from IDLE and check it cycle by cycle until it is back in IDLE.
    // lcd_delay: LCD_WAIT cycle in which lcd_done pulses (negative = never).
    task automatic run_instr(input logic [7:0] ib, input logic [7:0] o1, input logic [7:0] o2,
                             input int lcd_delay, input logic done_in_exec);
        exp_t e;
        int op;
        int fin;
        logic [7:0] sv;
        logic [8:0] jaddr;
        op    = int'(ib[7:4]);
        sv    = regs[ib[1:0]];
        jaddr = 9'(({8'h00, o2} << 8) | {8'h00, o1});
        chk("idle_ready", fetch.instr_ready, 1);
        fetch.instr_valid = 1'b1;
        fetch.instr_byte  = ib;
        fetch.operand1    = o1;
        fetch.operand2    = o2;
        e = model_exec(ib, o1, o2);
        tick();
        fetch.instr_valid = 1'b0;
        fetch.instr_byte  = 8'($urandom);
        fetch.operand1    = 8'($urandom);
        fetch.operand2    = 8'($urandom);
        lcd_done          = done_in_exec;
        #1;
        chk("ex_ready", fetch.instr_ready, 0);
        chk("ex_reg_we", reg_we, e.we);
        if (e.we) begin
            chk("ex_reg_addr", reg_addr, e.addr);
            chk("ex_reg_data", reg_data, e.data);
        end
        chk("ex_rd_en", rd_en, e.rd);
        chk("ex_wr_en", wr_en, e.wr);
        if (e.rd || e.wr) chk("ex_sram_addr", sram_addr, e.saddr);
        if (e.wr) chk("ex_sram_wdata", sram_wdata, e.wdata);
        chk("ex_strt", strt, e.strt);
        if (e.strt) chk("ex_lcd_data", lcd_data, e.lcd);
        chk("ex_jmp_en", fetch.jmp_en, e.jmp);
        if (op == 6) chk("ex_jmp_addr", fetch.jmp_addr, jaddr);
        if (op == 5) chk("ex_alu", {alu_inst, op_1, op_2}, {e.alu, e.o1, e.o2});
        chk("ex_retire", fetch.retire, e.ret);
        if (e.ret) chk("ex_size", fetch.instr_size, e.size);
        chk("ex_illegal", illegal, e.ill);
        chk("ex_hlt_lcd_err", {hlt, lcd_err}, {1'b0, exp_lcd_err});
        lcd_done = 1'b0;
        if (op == 2) begin
            for (int k = 1; k <= int'(LAT); k++) begin
                tick();
                chk("ld_rd_en", rd_en, 0);
                chk("ld_reg_we", reg_we, k == int'(LAT));
                chk("ld_retire", fetch.retire, k == int'(LAT));
                if (k == int'(LAT)) begin
                    chk("ld_reg_addr", reg_addr, ib[3:2]);
                    chk("ld_reg_data", reg_data, sram_rdata);
                    chk("ld_size", fetch.instr_size, 2);
                end
            end
        end else if (op == 4) begin
            fin = (lcd_delay >= 0 && lcd_delay < int'(TMO)) ? lcd_delay + 1 : int'(TMO);
            for (int k = 0; k <= fin; k++) begin
                tick();
                lcd_done = (k == lcd_delay);
                #1;
                chk("lcd_strt", strt, 0);
                chk("lcd_data_held", lcd_data, sv);
                chk("lcd_retire", fetch.retire, k == fin);
                if (k == fin) begin
                    if (fin == int'(TMO)) exp_lcd_err = 1'b1;
                    chk("lcd_size", fetch.instr_size, 1);
                    chk("lcd_err", lcd_err, exp_lcd_err);
                end
            end
            lcd_done = 1'b0;
        end
        if (op != 7) tick();
    endtask

    initial begin
        sys_rst           = 1'b1;
        fetch.instr_valid = 1'b0;
        fetch.instr_byte  = 8'h00;
        fetch.operand1    = 8'h00;
        fetch.operand2    = 8'h00;
        for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
        reg_flags  = 8'h00;
        sram_rdata = 8'h00;
        lcd_done   = 1'b0;
        #1;
        reset_checks("rst");
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        reset_checks("post_rst");

        run_instr(8'h10, 8'h42, 8'h00, -1, 1'b0);   // MOV A,#0x42
        regs[2] = 8'h33;
        run_instr(8'h06, 8'h00, 8'h00, -1, 1'b0);   // MOV B,C
        sram_rdata = 8'h55;
        run_instr(8'h28, 8'h20, 8'h00, -1, 1'b0);   // LD C,[0x20]
        regs[0] = 8'h11;
        run_instr(8'h40, 8'h00, 8'h00, 7, 1'b1);    // PRNT A, done after 7
        run_instr(8'h40, 8'h00, 8'h00, -1, 1'b0);   // PRNT A, timeout
        reg_flags = 8'h01;
        run_instr(8'h61, 8'hAB, 8'h01, -1, 1'b0);   // JMP Z taken
        reg_flags = 8'h00;
        run_instr(8'h61, 8'hAB, 8'h01, -1, 1'b0);   // JMP Z not taken
        run_instr(8'h9C, 8'hFF, 8'hFF, -1, 1'b0);   // illegal

        for (int n = 0; n < 80; n++) begin
            logic [7:0] ib;
            ib = 8'($urandom);
            if (ib[7:4] == 4'h7) ib[7:4] = 4'h5;
            for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
            reg_flags  = 8'($urandom);
            sram_rdata = 8'($urandom);
            run_instr(ib, 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                      1'($urandom));
        end
        chk("lcd_err_sticky", lcd_err, 1);

        // Reset while waiting on the LCD abandons the print and clears the sticky error.
        fetch.instr_valid = 1'b1;
        fetch.instr_byte  = 8'h41;
        tick();
        fetch.instr_valid = 1'b0;
        tick();
        tick();
        tick();
        sys_rst = 1'b1;
        #1;
        exp_lcd_err = 1'b0;
        reset_checks("rst_lcd_wait");
        tick();
        sys_rst = 1'b0;
        tick();
        run_instr(8'h1C, 8'h77, 8'h00, -1, 1'b0);   // MOV D,#0x77 after reset

        run_instr(8'h70, 8'h00, 8'h00, -1, 1'b0);   // HLT
        fetch.instr_valid = 1'b1;
        fetch.instr_byte  = 8'h10;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("halt_hlt", hlt, 1);
            chk("halt_ready", fetch.instr_ready, 0);
            chk("halt_strobes", {reg_we, fetch.retire, rd_en, wr_en, strt}, 0);
        end
        fetch.instr_valid = 1'b0;
        sys_rst = 1'b1;
        #1;
        reset_checks("rst_halt");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
